// File: rtl/psum_pkg.sv
// Shared types, default widths and the output conversion (ReLU + saturation) for the
// partial-sum reducer.
package psum_pkg;

  localparam int unsigned IN_W  = 16;
  localparam int unsigned ACC_W = 24;
  localparam int unsigned OUT_W = 16;

  typedef enum logic [0:0] {StIdle, StAccum} state_e;

  typedef struct packed {
    logic        sat;
    logic [63:0] val;
  } conv_t;

  // Works on a 64-bit sign-extended value so any ACC_W/OUT_W up to 63 bits can share it.
  // ReLU zeroing takes priority and never flags saturation.
  function automatic conv_t sat_relu(input logic signed [63:0] x,
                                     input int unsigned        out_w,
                                     input logic               relu_en);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    conv_t              r;
    hi    = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo    = -hi - 64'sd1;
    r.sat = 1'b0;
    r.val = x;
    if (relu_en && (x < 0)) begin
      r.val = '0;
    end else if (x > hi) begin
      r.val = hi;
      r.sat = 1'b1;
    end else if (x < lo) begin
      r.val = lo;
      r.sat = 1'b1;
    end
    return r;
  endfunction

endpackage

// File: rtl/psum_fifo.sv
// Synchronous FIFO with registered storage, wrap-around pointers and an occupancy count.
module psum_fifo #(
  parameter int unsigned Width = 17,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = $clog2(Depth),
  localparam int unsigned CntW = PtrW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        mem_q[i] <= '0;
      end
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wptr_q] <= wdata_i;
        wptr_q        <= wptr_q + 1'b1;
      end
      if (pop_i) begin
        rptr_q <= rptr_q + 1'b1;
      end
      if (push_i && !pop_i) begin
        count_q <= count_q + 1'b1;
      end else if (pop_i && !push_i) begin
        count_q <= count_q - 1'b1;
      end
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/psum_reducer.sv
// Reduces the PE lanes each beat, accumulates over a first/last-delimited window and queues
// the converted (ReLU/saturated) result in an output FIFO.
module psum_reducer #(
  parameter int unsigned LANES = 4,
  parameter int unsigned IN_W  = psum_pkg::IN_W,
  parameter int unsigned ACC_W = psum_pkg::ACC_W,
  parameter int unsigned OUT_W = psum_pkg::OUT_W,
  parameter int unsigned DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [LANES*IN_W-1:0] pe_out,
  input  logic                  in_valid,
  input  logic                  in_first,
  input  logic                  in_last,
  output logic                  in_ready,
  input  logic                  relu_en,
  output logic [OUT_W-1:0]      out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_sat,
  output logic                  err_proto
);

  import psum_pkg::*;

  localparam int unsigned SUM_W = IN_W + $clog2(LANES);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  state_e             state_q;
  logic [ACC_W-1:0]   acc_q;
  logic               err_q;

  logic [IN_W-1:0]    lane;
  logic [SUM_W-1:0]   lane_sum;
  logic [ACC_W-1:0]   lane_ext;
  logic [ACC_W-1:0]   acc_sum;
  logic [ACC_W-1:0]   push_val;
  logic               beat;
  logic               push;
  logic               pop;
  conv_t              conv;
  logic [OUT_W:0]     push_data;
  logic [OUT_W:0]     head;
  logic [CNT_W-1:0]   count;
  logic               unused_conv_hi;

  always_comb begin
    lane     = '0;
    lane_sum = '0;
    for (int i = 0; i < LANES; i++) begin
      lane     = pe_out[i*IN_W +: IN_W];
      lane_sum = lane_sum + {{(SUM_W-IN_W){lane[IN_W-1]}}, lane};
    end
    lane_ext = {{(ACC_W-SUM_W){lane_sum[SUM_W-1]}}, lane_sum};
    acc_sum  = acc_q + lane_ext;
  end

  assign beat = in_valid & in_ready;

  // A first beat always restarts from lane_sum, even one that arrives mid-window.
  always_comb begin
    push     = 1'b0;
    push_val = lane_ext;
    if (beat && in_last) begin
      if (state_q == StAccum) begin
        push     = 1'b1;
        push_val = in_first ? lane_ext : acc_sum;
      end else if (in_first) begin
        push = 1'b1;
      end
    end
    conv      = sat_relu({{(64-ACC_W){push_val[ACC_W-1]}}, push_val}, OUT_W, relu_en);
    push_data = {conv.sat, conv.val[OUT_W-1:0]};
  end

  assign unused_conv_hi = ^conv.val[63:OUT_W];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      acc_q   <= '0;
      err_q   <= 1'b0;
    end else if (beat) begin
      unique case (state_q)
        StIdle: begin
          if (!in_first) begin
            err_q <= 1'b1;
          end else if (!in_last) begin
            acc_q   <= lane_ext;
            state_q <= StAccum;
          end
        end
        StAccum: begin
          if (in_first) begin
            err_q <= 1'b1;
          end
          if (in_last) begin
            state_q <= StIdle;
          end else begin
            acc_q <= in_first ? lane_ext : acc_sum;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign in_ready  = (count != CNT_W'(DEPTH));

  psum_fifo #(
    .Width(OUT_W + 1),
    .Depth(DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .rst_i  (rst),
    .push_i (push),
    .wdata_i(push_data),
    .pop_i  (pop),
    .rdata_o(head),
    .count_o(count)
  );

  assign out_data  = head[OUT_W-1:0];
  assign out_sat   = head[OUT_W];
  assign err_proto = err_q;

endmodule

// File: tb/tb_psum_reducer.sv
// Directed and random checks of psum_reducer against a plain-arithmetic window model.
module tb_psum_reducer;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] pe_out;
  logic        in_valid, in_first, in_last, relu_en, out_ready;
  logic        in_ready, out_valid, out_sat, err_proto;
  logic [15:0] out_data;

  int total = 0;
  int bad   = 0;

  // Model state: expected FIFO contents {sat, data}, open window, running sum, sticky error.
  logic [16:0] exp_q[$];
  bit          m_in_win;
  longint      m_acc;
  bit          m_err;

  always #5 clk = ~clk;

  psum_reducer #(
    .LANES(4),
    .IN_W (16),
    .ACC_W(24),
    .OUT_W(16),
    .DEPTH(4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .pe_out   (pe_out),
    .in_valid (in_valid),
    .in_first (in_first),
    .in_last  (in_last),
    .in_ready (in_ready),
    .relu_en  (relu_en),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_sat  (out_sat),
    .err_proto(err_proto)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic longint lanes_sum(input logic [63:0] l);
    longint s = 0;
    logic [15:0] v;
    for (int i = 0; i < 4; i++) begin
      v = l[i*16 +: 16];
      s += longint'($signed(v));
    end
    return s;
  endfunction

  function automatic longint wrap24(input longint x);
    longint v;
    v = x & 64'h0000_0000_00FF_FFFF;
    if (v > 64'sd8388607) v = v - 64'sd16777216;
    return v;
  endfunction

  function automatic logic [16:0] ref_f(input longint x, input bit relu);
    if (relu && x < 0) return 17'h0;
    if (x > 32767) return {1'b1, 16'h7FFF};
    if (x < -32768) return {1'b1, 16'h8000};
    return {1'b0, x[15:0]};
  endfunction

  function automatic void model_accept(input logic [63:0] l, input bit f, input bit la,
                                       input bit r);
    longint s = lanes_sum(l);
    if (!m_in_win) begin
      if (!f) m_err = 1'b1;
      else if (la) exp_q.push_back(ref_f(s, r));
      else begin
        m_acc    = s;
        m_in_win = 1'b1;
      end
    end else begin
      if (f) begin
        m_err = 1'b1;
        m_acc = s;
      end else begin
        m_acc = wrap24(m_acc + s);
      end
      if (la) begin
        exp_q.push_back(ref_f(m_acc, r));
        m_in_win = 1'b0;
      end
    end
  endfunction

  // Called at posedge+1; returns at posedge+1 just after the accepting edge.
  task automatic send(input logic [63:0] l, input bit f, input bit la, input bit r);
    int n = 0;
    pe_out   = l;
    in_valid = 1'b1;
    in_first = f;
    in_last  = la;
    relu_en  = r;
    while (!in_ready && n < 50) begin
      if (n >= 2) out_ready = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      chk("in_ready_timeout", in_ready, 1);
    end else begin
      @(posedge clk); #1;
      model_accept(l, f, la, r);
    end
    in_valid = 1'b0;
    in_first = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    out_ready = 1'b1;
    while ((out_valid || exp_q.size() != 0) && n < 30) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain_empty", out_valid, 0);
  endtask

  // Scoreboard: occupancy and head order checked every cycle away from the edge.
  always @(negedge clk) begin
    if (!rst) begin
      chk("valid_vs_model", out_valid, exp_q.size() != 0);
      if (out_valid && out_ready && exp_q.size() != 0) begin
        chk("pop_head", {out_sat, out_data}, exp_q.pop_front());
      end
    end
  end

  localparam logic [63:0] TP_LANES = {16'h0100, 16'h0090, 16'h0040, 16'h0010};

  initial begin
    logic [63:0] l;
    int          len;
    bit          r;
    rst = 1'b1;
    pe_out = '0; in_valid = 0; in_first = 0; in_last = 0; relu_en = 0; out_ready = 0;
    m_in_win = 0; m_acc = 0; m_err = 0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_err", err_proto, 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Single-beat window
    send(TP_LANES, 1, 1, 0);
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 16'h01E0);
    chk("single_sat", out_sat, 0);
    drain();

    // Three-beat window
    out_ready = 1'b1;
    send(TP_LANES, 1, 0, 0);
    send(TP_LANES, 0, 0, 0);
    chk("three_mid_valid", out_valid, 0);
    send(TP_LANES, 0, 1, 0);
    chk("three_valid", out_valid, 1);
    chk("three_data", out_data, 16'h05A0);
    drain();

    // ReLU on and off
    send(64'h0000_0000_0000_FFF0, 1, 1, 1);
    chk("relu_on_data", out_data, 16'h0000);
    chk("relu_on_sat", out_sat, 0);
    drain();
    send(64'h0000_0000_0000_FFF0, 1, 1, 0);
    chk("relu_off_data", out_data, 16'hFFF0);
    drain();

    // Saturation both directions
    send({4{16'h7FFF}}, 1, 0, 0);
    send({4{16'h7FFF}}, 0, 1, 0);
    chk("sat_pos_data", out_data, 16'h7FFF);
    chk("sat_pos_sat", out_sat, 1);
    drain();
    send({4{16'h8000}}, 1, 0, 1'b0);
    send({4{16'h8000}}, 0, 1, 1'b0);
    chk("sat_neg_data", out_data, 16'h8000);
    chk("sat_neg_sat", out_sat, 1);
    drain();

    // Accumulator wraps at 24 bits before saturation: 70 * 131068 wraps negative
    send({4{16'h7FFF}}, 1, 0, 0);
    for (int i = 0; i < 68; i++) send({4{16'h7FFF}}, 0, 0, 0);
    send({4{16'h7FFF}}, 0, 1, 0);
    chk("wrap_data", out_data, 16'h8000);
    chk("wrap_sat", out_sat, 1);
    drain();

    // FIFO full: four results held, fifth beat stalls until the consumer drains
    out_ready = 1'b0;
    for (int n = 1; n <= 4; n++) send(64'(n), 1, 1, 0);
    chk("full_in_ready", in_ready, 0);
    pe_out = 64'd5; in_valid = 1; in_first = 1; in_last = 1; relu_en = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("full_held", in_ready, 0);
    end
    chk("full_head", out_data, 16'd1);
    out_ready = 1'b1;
    send(64'd5, 1, 1, 0);
    chk("push_pop_ready", in_ready, 1);
    drain();

    // Protocol error: beat without first in IDLE is dropped
    chk("err_before", err_proto, 0);
    send(TP_LANES, 0, 1, 0);
    chk("err_set", err_proto, 1);
    chk("err_dropped", out_valid, 0);

    // Reset mid-window with two queued results
    out_ready = 1'b0;
    send(TP_LANES, 1, 1, 0);
    send(64'd7, 1, 1, 0);
    send(64'd9, 1, 0, 0);
    rst = 1'b1;
    exp_q.delete();
    m_in_win = 0; m_acc = 0; m_err = 0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_err", err_proto, 0);
    chk("mid_rst_ready", in_ready, 1);
    @(posedge clk); #1;
    rst = 1'b0;
    send(TP_LANES, 1, 0, 0);
    send(TP_LANES, 0, 1, 0);
    chk("post_rst_data", out_data, 16'h03C0);
    chk("post_rst_err", err_proto, 0);
    drain();

    // Random windows with occasional missing first and random back-pressure
    for (int w = 0; w < 60; w++) begin
      len = $urandom_range(1, 4);
      r   = 1'($urandom_range(0, 1));
      for (int b = 0; b < len; b++) begin
        if (w % 2 == 0) begin
          l = {$urandom, $urandom};
        end else begin
          for (int k = 0; k < 4; k++) l[k*16 +: 16] = 16'($urandom_range(0, 511) - 256);
        end
        out_ready = 1'($urandom_range(0, 1));
        send(l, (b == 0) && ($urandom_range(0, 7) != 0), b == len - 1, r);
      end
      chk("rand_err", err_proto, m_err);
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
